// File: rtl/board_pkg.sv
// Shared types and constants for the board timebase / reset sequencer.
package board_pkg;

  typedef enum logic [1:0] {
    POR  = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } rst_state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_EXT  = 2'b01;
  localparam logic [1:0] CAUSE_MAN  = 2'b10;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_div.sv
// Runtime-loadable divider: 50% square wave plus a one-cycle tick on its rising edge.
module tick_div #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DIV_DEFAULT = 59999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             tick,
  output logic             tick_sq
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_sq_q, tick_sq_d;
  logic             tick_q, tick_d;

  // A load restarts the half period without touching the square wave.
  always_comb begin
    cnt_d     = cnt_q + DIV_W'(1);
    div_d     = div_q;
    tick_sq_d = tick_sq_q;
    tick_d    = 1'b0;
    if (div_load) begin
      div_d = div_in;
      cnt_d = '0;
    end else if (cnt_q == div_q) begin
      cnt_d     = '0;
      tick_sq_d = ~tick_sq_q;
      tick_d    = ~tick_sq_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      div_q     <= DIV_W'(DIV_DEFAULT);
      tick_sq_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      tick_sq_q <= tick_sq_d;
      tick_q    <= tick_d;
    end
  end

  assign tick    = tick_q;
  assign tick_sq = tick_sq_q;

endmodule

// File: rtl/clk_reset_gen.sv
// Board timebase and reset sequencer: slow tick/clock, stretched power-on reset and
// debounced push-button manual reset with a sticky cause register.
module clk_reset_gen
  import board_pkg::*;
#(
  parameter int unsigned DIV_DEFAULT    = 59999,
  parameter int unsigned DIV_W          = 16,
  parameter int unsigned POR_TICKS      = 4,
  parameter int unsigned DEBOUNCE_TICKS = 3,
  parameter int unsigned NBTN           = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBTN-1:0]  btn,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  input  logic             cause_clr,
  output logic             tick,
  output logic             tick_sq,
  output logic             sys_reset,
  output logic [1:0]       cause
);

  localparam int unsigned POR_W = cnt_width(POR_TICKS);
  localparam int unsigned DB_W  = cnt_width(DEBOUNCE_TICKS);
  localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_TICKS - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_TICKS - 1);

  tick_div #(
    .DIV_W      (DIV_W),
    .DIV_DEFAULT(DIV_DEFAULT)
  ) u_tick_div (
    .clk     (clk),
    .reset   (reset),
    .div_in  (div_in),
    .div_load(div_load),
    .tick    (tick),
    .tick_sq (tick_sq)
  );

  logic [NBTN-1:0]  sync1_q, sync1_d;
  logic [NBTN-1:0]  sync2_q, sync2_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [POR_W-1:0] por_cnt_q, por_cnt_d;
  rst_state_t       state_q, state_d;
  logic             sys_reset_q, sys_reset_d;
  logic [1:0]       cause_q, cause_d;
  logic             combo;
  logic             manual_det;

  assign combo      = &sync2_q;
  assign manual_det = combo & tick & (db_cnt_q == DB_LAST);

  // Debounce saturates at its last step so a held combo keeps qualifying.
  always_comb begin
    sync1_d   = btn;
    sync2_d   = sync1_q;
    db_cnt_d  = db_cnt_q;
    state_d   = state_q;
    por_cnt_d = por_cnt_q;
    cause_d   = cause_q;

    if (!combo) begin
      db_cnt_d = '0;
    end else if (tick && (db_cnt_q != DB_LAST)) begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end

    if (cause_clr) begin
      cause_d = CAUSE_NONE;
    end

    case (state_q)
      POR: begin
        if (tick) begin
          if (por_cnt_q == POR_LAST) begin
            state_d   = RUN;
            por_cnt_d = '0;
          end else begin
            por_cnt_d = por_cnt_q + POR_W'(1);
          end
        end
      end
      RUN: begin
        if (manual_det) begin
          state_d = HOLD;
          cause_d = CAUSE_MAN;
        end
      end
      HOLD: begin
        if (!combo) begin
          state_d   = POR;
          por_cnt_d = '0;
        end
      end
      default: begin
        state_d   = POR;
        por_cnt_d = '0;
      end
    endcase

    sys_reset_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_cnt_q    <= '0;
      por_cnt_q   <= '0;
      state_q     <= POR;
      sys_reset_q <= 1'b1;
      cause_q     <= CAUSE_EXT;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_cnt_q    <= db_cnt_d;
      por_cnt_q   <= por_cnt_d;
      state_q     <= state_d;
      sys_reset_q <= sys_reset_d;
      cause_q     <= cause_d;
    end
  end

  assign sys_reset = sys_reset_q;
  assign cause     = cause_q;

endmodule

// File: tb/tb_clk_reset_gen.sv
// Self-checking bench for clk_reset_gen with DIV_DEFAULT=3, POR_TICKS=4, DEBOUNCE_TICKS=3, NBTN=3.
module tb_clk_reset_gen;
  import board_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  btn;
  logic [15:0] div_in;
  logic        div_load;
  logic        cause_clr;
  logic        tick;
  logic        tick_sq;
  logic        sys_reset;
  logic [1:0]  cause;

  clk_reset_gen #(
    .DIV_DEFAULT   (3),
    .DIV_W         (16),
    .POR_TICKS     (4),
    .DEBOUNCE_TICKS(3),
    .NBTN          (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .div_in   (div_in),
    .div_load (div_load),
    .cause_clr(cause_clr),
    .tick     (tick),
    .tick_sq  (tick_sq),
    .sys_reset(sys_reset),
    .cause    (cause)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       tk;
    logic       sq;
    logic       sys;
    logic [1:0] cs;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [2:0]  btn;
    logic [15:0] div;
    logic        ld;
    logic        clr;
    int          n;
    exp_t        e;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs[NV];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  function automatic vec_t mk(input logic r, input logic [2:0] b, input logic [15:0] d,
                              input logic l, input logic c, input int n,
                              input logic tk, input logic sq, input logic sys, input logic [1:0] cs);
    vec_t v;
    v.rst = r; v.btn = b; v.div = d; v.ld = l; v.clr = c; v.n = n;
    v.e = '{tk: tk, sq: sq, sys: sys, cs: cs};
    return v;
  endfunction

  task automatic drive(input logic r, input logic [2:0] b, input logic [15:0] d,
                       input logic l, input logic c);
    reset = r; btn = b; div_in = d; div_load = l; cause_clr = c;
  endtask

  // Queue the expectation, advance n edges, then pop and compare on the falling edge.
  task automatic step(input int n, input exp_t e, input string name);
    exp_t want, got;
    exp_q.push_back(e);
    repeat (n) @(posedge clk);
    @(negedge clk);
    want = exp_q.pop_front();
    got  = '{tk: tick, sq: tick_sq, sys: sys_reset, cs: cause};
    n_vec++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got tick=%b sq=%b sys_reset=%b cause=%b, want tick=%b sq=%b sys_reset=%b cause=%b",
               name, got.tk, got.sq, got.sys, got.cs, want.tk, want.sq, want.sys, want.cs);
    end
  endtask

  // Count edges until sys_reset reaches target, bounded by max_cyc.
  task automatic wait_sys(input logic target, input int max_cyc, input int exp_cyc, input string name);
    int cyc;
    cyc = 0;
    while ((cyc < max_cyc) && (sys_reset !== target)) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if ((sys_reset !== target) || (cyc != exp_cyc)) begin
      n_mis++;
      $display("FAIL %s: sys_reset=%b after %0d cycles, want %b after %0d cycles",
               name, sys_reset, cyc, target, exp_cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; btn = '0; div_in = '0; div_load = 1'b0; cause_clr = 1'b0;

    // Columns: rst btn div ld clr cycles | tick sq sys_reset cause (t = cycles since reset release)
    vecs[0]  = mk(1, 3'b000, 0, 0, 0,  2, 0, 0, 1, 2'b01); // reset state
    vecs[1]  = mk(0, 3'b000, 0, 0, 0,  3, 0, 0, 1, 2'b01); // t=3
    vecs[2]  = mk(0, 3'b000, 0, 0, 0,  1, 1, 1, 1, 2'b01); // t=4 first tick
    vecs[3]  = mk(0, 3'b000, 0, 0, 0,  1, 0, 1, 1, 2'b01); // t=5
    vecs[4]  = mk(0, 3'b000, 0, 0, 0,  3, 0, 0, 1, 2'b01); // t=8 falling half
    vecs[5]  = mk(0, 3'b000, 0, 0, 0,  4, 1, 1, 1, 2'b01); // t=12
    vecs[6]  = mk(0, 3'b000, 0, 0, 0, 16, 1, 1, 1, 2'b01); // t=28 fourth tick
    vecs[7]  = mk(0, 3'b000, 0, 0, 0,  1, 0, 1, 0, 2'b01); // t=29 sys_reset falls
    vecs[8]  = mk(0, 3'b111, 0, 0, 1,  1, 0, 1, 0, 2'b00); // t=30 cause cleared
    vecs[9]  = mk(0, 3'b111, 0, 0, 0,  6, 1, 1, 0, 2'b00); // t=36 qualifying tick 1
    vecs[10] = mk(0, 3'b111, 0, 0, 0,  8, 1, 1, 0, 2'b00); // t=44 qualifying tick 2
    vecs[11] = mk(0, 3'b111, 0, 0, 0,  7, 0, 0, 0, 2'b00); // t=51
    vecs[12] = mk(0, 3'b111, 0, 0, 0,  1, 1, 1, 0, 2'b00); // t=52 qualifying tick 3
    vecs[13] = mk(0, 3'b111, 0, 0, 1,  1, 0, 1, 1, 2'b10); // t=53 HOLD beats cause_clr
    vecs[14] = mk(0, 3'b111, 0, 0, 0, 20, 0, 0, 1, 2'b10); // t=73 still HOLD
    vecs[15] = mk(0, 3'b000, 0, 0, 0, 27, 1, 1, 1, 2'b10); // t=100 fourth POR tick
    vecs[16] = mk(0, 3'b000, 0, 0, 0,  1, 0, 1, 0, 2'b10); // t=101 back in RUN
    vecs[17] = mk(0, 3'b111, 0, 0, 0, 16, 0, 1, 0, 2'b10); // t=117 two ticks held
    vecs[18] = mk(0, 3'b011, 0, 0, 0,  1, 0, 1, 0, 2'b10); // t=118 one-cycle glitch
    vecs[19] = mk(0, 3'b111, 0, 0, 0, 15, 0, 1, 0, 2'b10); // t=133 two more ticks, no reset
    vecs[20] = mk(0, 3'b110, 0, 0, 0, 30, 0, 0, 0, 2'b10); // t=163 partial combo
    vecs[21] = mk(0, 3'b110, 0, 1, 0,  1, 0, 0, 0, 2'b10); // t=164 load 0 over a wrap
    vecs[22] = mk(0, 3'b110, 0, 0, 0,  1, 1, 1, 0, 2'b10); // t=165
    vecs[23] = mk(0, 3'b110, 0, 0, 0,  1, 0, 0, 0, 2'b10); // t=166
    vecs[24] = mk(0, 3'b110, 0, 0, 0,  1, 1, 1, 0, 2'b10); // t=167
    vecs[25] = mk(0, 3'b110, 0, 0, 0,  4, 1, 1, 0, 2'b10); // t=171
    vecs[26] = mk(0, 3'b110, 7, 1, 0,  1, 0, 1, 0, 2'b10); // t=172 load 7, no tick
    vecs[27] = mk(0, 3'b110, 0, 0, 0,  8, 0, 0, 0, 2'b10); // t=180
    vecs[28] = mk(0, 3'b110, 0, 0, 0,  8, 1, 1, 0, 2'b10); // t=188
    vecs[29] = mk(0, 3'b110, 0, 0, 0, 15, 0, 0, 0, 2'b10); // t=203
    vecs[30] = mk(0, 3'b110, 0, 0, 0,  1, 1, 1, 0, 2'b10); // t=204

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].btn, vecs[i].div, vecs[i].ld, vecs[i].clr);
      step(vecs[i].n, vecs[i].e, $sformatf("vec%0d", i));
    end

    // Reset in the middle of the power-on stretch restarts it from zero.
    drive(1, 3'b000, 0, 0, 0);
    step(1, '{tk: 0, sq: 0, sys: 1, cs: 2'b01}, "rst_a");
    drive(0, 3'b000, 0, 0, 0);
    step(21, '{tk: 0, sq: 1, sys: 1, cs: 2'b01}, "por_mid");
    drive(1, 3'b000, 0, 0, 0);
    step(1, '{tk: 0, sq: 0, sys: 1, cs: 2'b01}, "rst_b");
    drive(0, 3'b000, 0, 0, 0);
    wait_sys(1'b0, 60, 29, "por_restart");

    // Manual reset, then external reset (with cause_clr) while in HOLD.
    drive(0, 3'b111, 0, 0, 0);
    wait_sys(1'b1, 60, 24, "man_enter");
    step(3, '{tk: 0, sq: 0, sys: 1, cs: 2'b10}, "hold_t56");
    drive(1, 3'b111, 0, 0, 1);
    step(1, '{tk: 0, sq: 0, sys: 1, cs: 2'b01}, "rst_in_hold");
    drive(0, 3'b000, 0, 0, 0);
    wait_sys(1'b0, 60, 29, "hold_rst_restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
